// File: rtl/loopback_writer.sv
// loopback_writer
// Drain side of the loopback datapath. Pops cache lines from the loopback
// FIFO and issues them as sequential write requests on the host write
// channel. Issue is throttled by channel almost-full and by a cap on
// outstanding (issued but unacknowledged) writes. Write responses are
// counted, and done is raised once every line has been acknowledged.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, base_addr,          run request; address and line count are
//   num_lines                  latched when start is accepted (IDLE/DONE)
//   fifo_deq_data, fifo_empty  FIFO head (combinational read) and status
//   fifo_deq_en                FIFO dequeue strobe (also the issue strobe)
//   tx_almost_full             write channel backpressure
//   tx_wr_valid/addr/data/     registered write request, one cycle after
//   mdata                      the dequeue
//   rx_wr_rsp_valid            one write response per cycle at most
//   done                       all lines issued and acknowledged
//   error                      sticky: response seen with nothing outstanding
//   lines_sent, lines_acked    per-run issue and response counters
module loopback_writer #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 42,
  parameter int MDATA_WIDTH     = 16,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [31:0]            num_lines,
  input  logic [DATA_WIDTH-1:0]  fifo_deq_data,
  input  logic                   fifo_empty,
  output logic                   fifo_deq_en,
  input  logic                   tx_almost_full,
  output logic                   tx_wr_valid,
  output logic [ADDR_WIDTH-1:0]  tx_wr_addr,
  output logic [DATA_WIDTH-1:0]  tx_wr_data,
  output logic [MDATA_WIDTH-1:0] tx_wr_mdata,
  input  logic                   rx_wr_rsp_valid,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            lines_sent,
  output logic [31:0]            lines_acked
);

  // One extra bit so the counter can hold MAX_OUTSTANDING itself.
  localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OUT_WIDTH-1:0] OUT_CAP = OUT_WIDTH'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [ADDR_WIDTH-1:0]  addr_base;
  logic [31:0]            target;
  logic [OUT_WIDTH-1:0]   outstanding;

  logic                   start_ok;
  logic                   issue;
  logic                   rsp_counted;
  logic                   spurious;
  logic [31:0]            sent_next;

  assign start_ok = start && ((state == IDLE) || (state == DONE));

  assign issue = (state == RUN) && !fifo_empty && !tx_almost_full &&
                 (lines_sent < target) && (outstanding < OUT_CAP);

  assign fifo_deq_en = issue;

  // A response that coincides with an issue is legal even at zero
  // outstanding: the issue supplies the write it acknowledges.
  assign rsp_counted = rx_wr_rsp_valid && ((outstanding != '0) || issue);
  assign spurious    = rx_wr_rsp_valid && !rsp_counted;

  assign sent_next = lines_sent + 32'(issue);
  assign done      = (state == DONE);

  // Next-state logic. RUN looks at the post-increment count so the move to
  // DRAIN happens on the same edge as the final issue.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (num_lines == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (sent_next == target) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Run parameters, captured once per accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_base <= '0;
      target    <= '0;
    end else if (start_ok) begin
      addr_base <= base_addr;
      target    <= num_lines;
    end
  end

  // Issue/response bookkeeping. error is sticky until reset; a spurious
  // response leaves both the outstanding count and lines_acked untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      lines_sent  <= '0;
      lines_acked <= '0;
      outstanding <= '0;
      error       <= 1'b0;
    end else begin
      if (spurious) begin
        error <= 1'b1;
      end
      if (start_ok) begin
        lines_sent  <= '0;
        lines_acked <= '0;
        outstanding <= '0;
      end else begin
        lines_sent <= sent_next;
        if (rsp_counted) begin
          lines_acked <= lines_acked + 32'd1;
        end
        outstanding <= outstanding + OUT_WIDTH'(issue) - OUT_WIDTH'(rsp_counted);
      end
    end
  end

  // Registered write request. Address wraps modulo 2^ADDR_WIDTH; payload
  // fields hold their last value while no request is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_valid <= 1'b0;
      tx_wr_addr  <= '0;
      tx_wr_data  <= '0;
      tx_wr_mdata <= '0;
    end else begin
      tx_wr_valid <= issue;
      if (issue) begin
        tx_wr_addr  <= addr_base + ADDR_WIDTH'(lines_sent);
        tx_wr_data  <= fifo_deq_data;
        tx_wr_mdata <= lines_sent[MDATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_loopback_writer.sv
// tb_loopback_writer
// Self-checking bench for loopback_writer. The bench plays both the loopback
// FIFO (array with read/write pointers) and the host write channel. Every
// write the DUT presents is recorded, and after each run it is compared with
// the expected write sequence: line k of a run goes to base+k (mod 2^42),
// carries tag k and the k-th line pushed for that run.
module tb_loopback_writer;

  localparam int DW = 512;
  localparam int AW = 42;
  localparam int MW = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [MW-1:0] mdata;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [31:0]   num_lines;
  logic [DW-1:0] fifo_deq_data;
  logic          fifo_empty;
  logic          fifo_deq_en;
  logic          tx_almost_full;
  logic          tx_wr_valid;
  logic [AW-1:0] tx_wr_addr;
  logic [DW-1:0] tx_wr_data;
  logic [MW-1:0] tx_wr_mdata;
  logic          rx_wr_rsp_valid;
  logic          done;
  logic          error;
  logic [31:0]   lines_sent;
  logic [31:0]   lines_acked;

  logic [DW-1:0] fifo_mem [0:1023];
  logic [9:0]    rd_ptr = '0;
  logic [9:0]    wr_ptr = '0;

  logic [DW-1:0] pushed[$];
  wr_t           obs[$];
  int            model_rd = 0;
  int            cyc = 0;
  int            af_viol = 0;
  int            total = 0;
  int            bad = 0;

  loopback_writer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .num_lines       (num_lines),
    .fifo_deq_data   (fifo_deq_data),
    .fifo_empty      (fifo_empty),
    .fifo_deq_en     (fifo_deq_en),
    .tx_almost_full  (tx_almost_full),
    .tx_wr_valid     (tx_wr_valid),
    .tx_wr_addr      (tx_wr_addr),
    .tx_wr_data      (tx_wr_data),
    .tx_wr_mdata     (tx_wr_mdata),
    .rx_wr_rsp_valid (rx_wr_rsp_valid),
    .done            (done),
    .error           (error),
    .lines_sent      (lines_sent),
    .lines_acked     (lines_acked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: head is a combinational read, a dequeue advances the pointer.
  assign fifo_deq_data = fifo_mem[rd_ptr];
  assign fifo_empty    = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_deq_en) rd_ptr <= rd_ptr + 10'd1;
  end

  // Write channel monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_wr_valid) obs.push_back('{tx_wr_addr, tx_wr_mdata, tx_wr_data, cyc});
    if (tx_almost_full && fifo_deq_en) af_viol++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic push_lines(input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
      fifo_mem[wr_ptr] = d;
      wr_ptr = wr_ptr + 10'd1;
      pushed.push_back(d);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] base, input logic [31:0] n);
    obs.delete();
    base_addr = base;
    num_lines = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_rsps(input int n);
    for (int i = 0; i < n; i++) begin
      rx_wr_rsp_valid = 1'b1;
      tick();
      rx_wr_rsp_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_sent(input string tag, input int n, input int budget);
    int i = 0;
    while (lines_sent != 32'(n) && i < budget) begin
      tick();
      i++;
    end
    checkOutput(tag, DW'(lines_sent), DW'(n));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while (done !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    checkOutput(tag, DW'(done), DW'(1));
  endtask

  task automatic verify_run(input string tag, input logic [AW-1:0] base, input int n);
    logic [AW-1:0] exp_addr;
    checkOutput({tag, "_wr_count"}, DW'(obs.size()), DW'(n));
    for (int k = 0; k < n && k < obs.size(); k++) begin
      exp_addr = base + AW'(k);
      checkOutput($sformatf("%s_addr[%0d]", tag, k), DW'(obs[k].addr), DW'(exp_addr));
      checkOutput($sformatf("%s_mdata[%0d]", tag, k), DW'(obs[k].mdata), DW'(MW'(k)));
      checkOutput($sformatf("%s_data[%0d]", tag, k), obs[k].data, pushed[model_rd + k]);
    end
    model_rd += n;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_valid"},  DW'(tx_wr_valid), DW'(0));
    checkOutput({tag, "_deq"},    DW'(fifo_deq_en), DW'(0));
    checkOutput({tag, "_done"},   DW'(done), DW'(0));
    checkOutput({tag, "_error"},  DW'(error), DW'(0));
    checkOutput({tag, "_sent"},   DW'(lines_sent), DW'(0));
    checkOutput({tag, "_acked"},  DW'(lines_acked), DW'(0));
    checkOutput({tag, "_addr"},   DW'(tx_wr_addr), DW'(0));
    checkOutput({tag, "_data"},   tx_wr_data, DW'(0));
    checkOutput({tag, "_mdata"},  DW'(tx_wr_mdata), DW'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Directed sequence with randomized data and response spacing.
  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    base_addr       = '0;
    num_lines       = '0;
    tx_almost_full  = 1'b0;
    rx_wr_rsp_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("por");

    $display("[TB] basic run");
    push_lines(4);
    applyStimulus(42'h100, 32'd4);
    wait_sent("basic_sent", 4, 50);
    tick();
    tick();
    send_rsps(4);
    wait_done("basic_done", 50);
    checkOutput("basic_acked", DW'(lines_acked), DW'(4));
    checkOutput("basic_error", DW'(error), DW'(0));
    if (obs.size() >= 4)
      checkOutput("basic_back_to_back", DW'(obs[3].cyc - obs[0].cyc), DW'(3));
    verify_run("basic", 42'h100, 4);

    $display("[TB] backpressure run");
    push_lines(8);
    applyStimulus(42'h2_0000, 32'd8);
    checkOutput("restart_done_drop", DW'(done), DW'(0));
    tick();
    tick();
    tx_almost_full = 1'b1;
    repeat (5) tick();
    checkOutput("bp_sent_frozen", DW'(lines_sent), DW'(2));
    tx_almost_full = 1'b0;
    wait_sent("bp_sent", 8, 50);
    tick();
    tick();
    send_rsps(8);
    wait_done("bp_done", 50);
    checkOutput("bp_af_deq", DW'(af_viol), DW'(0));
    checkOutput("bp_acked", DW'(lines_acked), DW'(8));
    verify_run("bp", 42'h2_0000, 8);

    $display("[TB] outstanding cap and simultaneous issue/response");
    push_lines(5);
    applyStimulus(42'h3000, 32'd20);
    wait_sent("cap_sent5", 5, 50);
    push_lines(1);
    rx_wr_rsp_valid = 1'b1;
    tick();
    rx_wr_rsp_valid = 1'b0;
    checkOutput("sim_sent", DW'(lines_sent), DW'(6));
    push_lines(14);
    repeat (30) tick();
    checkOutput("cap_stall_sent", DW'(lines_sent), DW'(17));
    checkOutput("cap_stall_acked", DW'(lines_acked), DW'(1));
    send_rsps(1);
    repeat (5) tick();
    checkOutput("cap_one_more", DW'(lines_sent), DW'(18));
    send_rsps(18);
    wait_done("cap_done", 60);
    checkOutput("cap_acked", DW'(lines_acked), DW'(20));
    checkOutput("cap_error", DW'(error), DW'(0));
    verify_run("cap", 42'h3000, 20);

    $display("[TB] zero-length run");
    do_reset();
    checkOutput("zero_pre_done", DW'(done), DW'(0));
    applyStimulus(42'h500, 32'd0);
    checkOutput("zero_done", DW'(done), DW'(1));
    repeat (3) tick();
    checkOutput("zero_sent", DW'(lines_sent), DW'(0));
    verify_run("zero", 42'h500, 0);

    $display("[TB] address wrap run");
    push_lines(3);
    applyStimulus(42'h3FF_FFFF_FFFE, 32'd3);
    wait_sent("wrap_sent", 3, 50);
    tick();
    tick();
    send_rsps(3);
    wait_done("wrap_done", 50);
    verify_run("wrap", 42'h3FF_FFFF_FFFE, 3);

    $display("[TB] reset mid-run");
    push_lines(3);
    applyStimulus(42'h7000, 32'd8);
    wait_sent("abort_sent", 3, 50);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("midrst");
    verify_run("abort", 42'h7000, 3);
    push_lines(4);
    applyStimulus(42'h8000, 32'd4);
    checkOutput("rerun_sent0", DW'(lines_sent), DW'(0));
    wait_sent("rerun_sent", 4, 50);
    tick();
    tick();
    send_rsps(4);
    wait_done("rerun_done", 50);
    checkOutput("rerun_acked", DW'(lines_acked), DW'(4));
    checkOutput("rerun_error", DW'(error), DW'(0));
    verify_run("rerun", 42'h8000, 4);

    $display("[TB] spurious response in IDLE");
    do_reset();
    checkOutput("spur_pre_error", DW'(error), DW'(0));
    rx_wr_rsp_valid = 1'b1;
    tick();
    rx_wr_rsp_valid = 1'b0;
    checkOutput("spur_error", DW'(error), DW'(1));
    checkOutput("spur_acked", DW'(lines_acked), DW'(0));
    repeat (5) tick();
    checkOutput("spur_error_sticky", DW'(error), DW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
